// File: rtl/player_entry_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : player_entry_ctrl
//  Purpose  : Two-player nibble entry with hidden values, reveal and scoring.
//             Optional macro AUTO_NEXT_ROUND_EN adds a reveal auto-advance timer.
//  Revision : 1.0  initial release
// ============================================================================
module player_entry_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 20,
    parameter int unsigned REVEAL_CYCLES   = 150000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       p1_inc_n,
    input  logic       p1_lock_n,
    input  logic       p2_inc_n,
    input  logic       p2_lock_n,
    input  logic       new_round,
    output logic [3:0] player1,
    output logic [3:0] player2,
    output logic       p1_locked,
    output logic       p2_locked,
    output logic       reveal,
    output logic       match,
    output logic [3:0] round_cnt,
    output logic [3:0] score_match
);

    localparam int unsigned      c_n_btn   = 5;
    localparam logic [CNT_W-1:0] c_db_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [0:0] {
        S_ENTRY  = 1'b0,
        S_REVEAL = 1'b1
    } state_t;

    // Bit order: 0 p1_inc, 1 p1_lock, 2 p2_inc, 3 p2_lock, 4 new_round (all active-high here)
    logic [c_n_btn-1:0] w_raw;
    logic [c_n_btn-1:0] w_press;

    assign w_raw = {new_round, ~p2_lock_n, ~p2_inc_n, ~p1_lock_n, ~p1_inc_n};

    genvar gi;
    generate
        for (gi = 0; gi < c_n_btn; gi++) begin : g_cond
            logic [1:0]       r_sync;
            logic [CNT_W-1:0] r_cnt;
            logic             r_level;
            logic             r_press;

            // Level flips only after DEBOUNCE_CYCLES consecutive samples disagree with it
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_sync  <= 2'b00;
                    r_cnt   <= '0;
                    r_level <= 1'b0;
                    r_press <= 1'b0;
                end else begin
                    r_sync  <= {r_sync[0], w_raw[gi]};
                    r_press <= 1'b0;
                    if (r_sync[1] == r_level) begin
                        r_cnt <= '0;
                    end else if (r_cnt == c_db_last) begin
                        r_cnt   <= '0;
                        r_level <= r_sync[1];
                        r_press <= r_sync[1];
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
            end

            assign w_press[gi] = r_press;
        end
    endgenerate

    state_t     r_state, w_state_nx;
    logic [3:0] r_v1, r_v2, w_v1_nx, w_v2_nx;
    logic       r_l1, r_l2, w_l1_nx, w_l2_nx;
    logic [3:0] r_player1, r_player2, w_player1_nx, w_player2_nx;
    logic       r_reveal, r_match, w_reveal_nx, w_match_nx;
    logic [3:0] r_round, r_score, w_round_nx, w_score_nx;
    logic       w_restart;

`ifdef AUTO_NEXT_ROUND_EN
    localparam int unsigned          c_tmr_w    = $clog2(REVEAL_CYCLES + 1);
    localparam logic [c_tmr_w-1:0]   c_tmr_last = c_tmr_w'(REVEAL_CYCLES - 1);
    logic [c_tmr_w-1:0] r_timer;
    logic               w_timeout;

    assign w_timeout = (r_state == S_REVEAL) && (r_timer == c_tmr_last);
    assign w_restart = w_press[4] | w_timeout;

    always_ff @(posedge clk) begin
        if (rst || r_state != S_REVEAL || w_restart) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + c_tmr_w'(1);
        end
    end
`else
    assign w_restart = w_press[4];

    // The reveal hold time only matters to the auto-advance timer
    if (REVEAL_CYCLES == 0) begin : g_reveal_cfg_unused
    end
`endif

    always_comb begin
        w_state_nx   = r_state;
        w_v1_nx      = r_v1;
        w_v2_nx      = r_v2;
        w_l1_nx      = r_l1;
        w_l2_nx      = r_l2;
        w_player1_nx = r_player1;
        w_player2_nx = r_player2;
        w_reveal_nx  = r_reveal;
        w_match_nx   = r_match;
        w_round_nx   = r_round;
        w_score_nx   = r_score;

        if (w_restart) begin
            w_state_nx   = S_ENTRY;
            w_v1_nx      = 4'd0;
            w_v2_nx      = 4'd0;
            w_l1_nx      = 1'b0;
            w_l2_nx      = 1'b0;
            w_player1_nx = 4'd0;
            w_player2_nx = 4'd0;
            w_reveal_nx  = 1'b0;
            w_match_nx   = 1'b0;
        end else if (r_state == S_ENTRY) begin
            // Increment is judged against the pre-lock flag so inc+lock keeps the increment
            if (w_press[0] && !r_l1) w_v1_nx = r_v1 + 4'd1;
            if (w_press[2] && !r_l2) w_v2_nx = r_v2 + 4'd1;
            w_l1_nx = r_l1 | w_press[1];
            w_l2_nx = r_l2 | w_press[3];
            if (w_l1_nx && w_l2_nx) begin
                w_state_nx   = S_REVEAL;
                w_player1_nx = w_v1_nx;
                w_player2_nx = w_v2_nx;
                w_reveal_nx  = 1'b1;
                w_match_nx   = (w_v1_nx == w_v2_nx);
                w_round_nx   = (r_round == 4'hF) ? r_round : r_round + 4'd1;
                if (w_v1_nx == w_v2_nx && r_score != 4'hF) w_score_nx = r_score + 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_ENTRY;
            r_v1      <= 4'd0;
            r_v2      <= 4'd0;
            r_l1      <= 1'b0;
            r_l2      <= 1'b0;
            r_player1 <= 4'd0;
            r_player2 <= 4'd0;
            r_reveal  <= 1'b0;
            r_match   <= 1'b0;
            r_round   <= 4'd0;
            r_score   <= 4'd0;
        end else begin
            r_state   <= w_state_nx;
            r_v1      <= w_v1_nx;
            r_v2      <= w_v2_nx;
            r_l1      <= w_l1_nx;
            r_l2      <= w_l2_nx;
            r_player1 <= w_player1_nx;
            r_player2 <= w_player2_nx;
            r_reveal  <= w_reveal_nx;
            r_match   <= w_match_nx;
            r_round   <= w_round_nx;
            r_score   <= w_score_nx;
        end
    end

    assign player1     = r_player1;
    assign player2     = r_player2;
    assign p1_locked   = r_l1;
    assign p2_locked   = r_l2;
    assign reveal      = r_reveal;
    assign match       = r_match;
    assign round_cnt   = r_round;
    assign score_match = r_score;

endmodule
`default_nettype wire

// File: doc/player_entry_ctrl.md
Name: player_entry_ctrl

Overview:
- Upstream stage for the two-player nibble display/compare path on the DE0 board.
- Turns four raw active-low pushbuttons into per-player 4-bit entries: each player has one increment key and one lock key.
- Values stay hidden until both players have locked. The block then reveals both nibbles to the 7-segment/compare stage, flags a match, and keeps round and match counters.

Parameters:
- DEBOUNCE_CYCLES, 500000, consecutive stable samples required to accept a button level (10 ms at 50 MHz).
- CNT_W, 20, debounce counter width; must hold DEBOUNCE_CYCLES.
- REVEAL_CYCLES, 150000000, reveal hold time; used only with AUTO_NEXT_ROUND_EN.

Ports:
- clk  in  1  system clock (50 MHz).
- rst  in  1  synchronous, active-high reset.
- p1_inc_n  in  1  raw pushbutton, active-low; player 1 increment.
- p1_lock_n  in  1  raw pushbutton, active-low; player 1 lock.
- p2_inc_n  in  1  raw pushbutton, active-low; player 2 increment.
- p2_lock_n  in  1  raw pushbutton, active-low; player 2 lock.
- new_round  in  1  raw switch/button, active-high; starts the next round.
- player1  out  4  player 1 nibble to the display/compare stage.
- player2  out  4  player 2 nibble to the display/compare stage.
- p1_locked  out  1  player 1 has locked this round.
- p2_locked  out  1  player 2 has locked this round.
- reveal  out  1  high while in REVEAL.
- match  out  1  player1==player2, qualified by reveal.
- round_cnt  out  4  completed rounds, saturating.
- score_match  out  4  rounds ending in a match, saturating.

Behaviour:
- One clock (clk). Reset is synchronous and active-high (rst). Polarity and synchronicity are fixed.
- Reset values: player1=player2=0, p1_locked=p2_locked=0, reveal=0, match=0, round_cnt=0, score_match=0. State=ENTRY. Internal values v1=v2=0.
- Input conditioning, applied to all five inputs:
  - 2-flop synchroniser, then debouncer.
  - Debounced level updates only after DEBOUNCE_CYCLES consecutive identical synchronised samples.
  - Press event is a 1-cycle pulse on the debounced released→pressed transition.
  - Raw-to-pulse latency: 2 + DEBOUNCE_CYCLES (+1) cycles.
- Debouncer reset state is "released", counter 0. A button held through reset produces a pulse one debounce period after rst deasserts.
- State ENTRY:
  - inc pulse for an unlocked player: v = v+1 mod 16 (15→0).
  - lock pulse: sets that player's locked flag. It is sticky until a new round or reset.
  - inc and lock pulses for the same player in the same cycle: increment applied, then lock (locked value includes the increment).
  - player1/player2 driven to 0 and match=0 while in ENTRY.
  - When both locked flags are set (sequentially or in the same cycle), go to REVEAL on the next edge.
- Transition into REVEAL, registered in one cycle:
  - player1=v1, player2=v2, reveal=1, match=(v1==v2).
  - round_cnt += 1, saturating at 15.
  - score_match += 1 if match, saturating at 15.
  - Counters update exactly once per round.
- State REVEAL: inc/lock pulses are ignored; outputs hold.
- new_round pulse, from either state:
  - Next cycle: state=ENTRY, v1=v2=0, locked flags cleared, player1/player2=0, reveal=0, match=0.
  - Counters are retained.
  - new_round pulse in ENTRY with partial entries discards them; counters unchanged.
- new_round pulse coincident with the second lock: new_round wins; no reveal and no counter update.
- rst mid-round or mid-debounce: everything returns to reset values on the next edge, including the counters.

Optional Feature:
- Macro: AUTO_NEXT_ROUND_EN.
- Defined: a reveal timer starts on entry to REVEAL. After REVEAL_CYCLES cycles in REVEAL, the block performs the new_round action automatically. A manual new_round pulse also works and resets the timer.
- Not defined: no timer logic; REVEAL persists until a new_round pulse or rst. REVEAL_CYCLES is unused.

Test Plan (sim with DEBOUNCE_CYCLES=4):
1. Reset: assert rst 2 cycles with all buttons released → all outputs 0, reveal=0; no pulses afterwards.
2. Bounce: p1_inc_n low 2 cycles, high 1 cycle, low 3 cycles, then stable low 10 cycles → exactly one increment. Confirm by locking both (v2=0): reveal shows player1=1, player2=0, match=0.
3. Wrap and match: 19 p1 presses, 3 p2 presses, p1 lock, then p2 lock → reveal=1 one cycle after the p2 lock pulse; player1=3, player2=3, match=1, round_cnt=1, score_match=1.
4. Same-cycle locks with v1=5, v2=9 → reveal; match=0, score_match unchanged, round_cnt+1. Extra inc presses during REVEAL → player1 stays 5.
5. Lock then inc: p1 locks at 2, then presses inc twice → revealed player1=2. new_round during REVEAL → next cycle reveal=0, outputs 0, locks clear, counters kept.
6. 16 complete matching rounds → round_cnt=15 and score_match=15 (saturated). Hold p2_inc_n low through rst → one increment 2+4 cycles after release. With AUTO_NEXT_ROUND_EN and REVEAL_CYCLES=8 → reveal drops after 8 cycles.
